freq_sweep_master: RTL and testbench

//  Bus master that drives the frequency-counter register interface to sweep all enabled designs.
//  Per design it programs sample count and input select, starts a measurement, waits for irq,

---
 rtl/freq_sweep_master.sv | 249 ++++++++++++++++++++++++
 tb/tb_freq_sweep_master.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_sweep_master.sv
// freq_sweep_master
// Sweeps every enabled design through the frequency counter. For each design it
// programs the sample count and input select, starts a measurement, waits for the
// completion irq, reads the result and pushes {timeout_err, design_idx, value}
// into a small show-ahead result FIFO for the host/logging stage.
module freq_sweep_master #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int NDESIGNS     = 24,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_SAMPLES = 0,
    parameter int ADDR_SELECT  = 1,
    parameter int ADDR_START   = 2,
    parameter int ADDR_RESULT  = 3,
    parameter int START_VAL    = 1,
    parameter int TIMEOUT      = 1000000,
    localparam int IDXW        = $clog2(NDESIGNS),
    localparam int ENTRY_W     = 1 + IDXW + DATA_WIDTH,
    localparam int CNTW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sweep_start,
    input  logic [NDESIGNS-1:0]   sweep_mask,
    input  logic [DATA_WIDTH-1:0] samples_cfg,
    output logic                  busy,
    output logic                  sweep_done,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic                  m_read,
    input  logic [DATA_WIDTH-1:0] m_readdata,
    input  logic                  m_readdatavalid,
    output logic                  m_write,
    output logic [DATA_WIDTH-1:0] m_writedata,
    input  logic                  irq,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ENTRY_W-1:0]    res_data,
    output logic [CNTW-1:0]       res_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SCAN,
        S_WR_SAMP,
        S_WR_SEL,
        S_WR_START,
        S_WAIT_IRQ,
        S_RD_REQ,
        S_RD_WAIT,
        S_IRQ_REL,
        S_PUSH,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [NDESIGNS-1:0]   pend_q, pend_d;
    logic [DATA_WIDTH-1:0] samp_q, samp_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;
    logic                  err_q, err_d;
    logic [IDXW-1:0]       first_idx;
    logic                  tmo_hit;

    logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]       count_q;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;

    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));
    assign fifo_full = (count_q == CNTW'(FIFO_DEPTH));
    assign push      = (state_q == S_PUSH) && !fifo_full;
    assign pop       = (count_q != '0) && res_ready;
    assign busy      = (state_q != S_IDLE);
    assign res_valid = (count_q != '0);
    assign res_data  = mem_q[rd_ptr_q];
    assign res_count = count_q;

    // Lowest still-pending design, so SCAN skips disabled designs in a single cycle.
    always_comb begin
        first_idx = '0;
        for (int i = NDESIGNS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                first_idx = IDXW'(i);
            end
        end
    end

    // Sweep state and per-design measurement registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
            samp_q  <= '0;
            tmo_q   <= '0;
            val_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            samp_q  <= samp_d;
            tmo_q   <= tmo_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and bus strobes; the timeout counter runs only in the wait states.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        samp_d      = samp_q;
        tmo_d       = '0;
        val_d       = val_q;
        err_d       = err_q;
        m_address   = '0;
        m_read      = 1'b0;
        m_write     = 1'b0;
        m_writedata = '0;
        sweep_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sweep_start) begin
                    pend_d  = sweep_mask;
                    samp_d  = samples_cfg;
                    idx_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (pend_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = first_idx;
                    err_d   = 1'b0;
                    val_d   = '0;
                    state_d = S_WR_SAMP;
                end
            end
            S_WR_SAMP: begin
                m_write     = 1'b1;
                m_address   = ADDR_WIDTH'(ADDR_SAMPLES);
                m_writedata = samp_q;
                state_d     = S_WR_SEL;
            end
            S_WR_SEL: begin
                m_write     = 1'b1;
                m_address   = ADDR_WIDTH'(ADDR_SELECT);
                m_writedata = DATA_WIDTH'(idx_q);
                state_d     = S_WR_START;
            end
            S_WR_START: begin
                m_write     = 1'b1;
                m_address   = ADDR_WIDTH'(ADDR_START);
                m_writedata = DATA_WIDTH'(START_VAL);
                state_d     = S_WAIT_IRQ;
            end
            S_WAIT_IRQ: begin
                if (irq) begin
                    state_d = S_RD_REQ;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    val_d   = '1;
                    state_d = S_PUSH;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RD_REQ: begin
                m_read    = 1'b1;
                m_address = ADDR_WIDTH'(ADDR_RESULT);
                state_d   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (m_readdatavalid) begin
                    val_d   = m_readdata;
                    state_d = S_IRQ_REL;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    val_d   = '1;
                    state_d = S_PUSH;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_IRQ_REL: begin
                if (!irq) begin
                    state_d = S_PUSH;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    val_d   = '1;
                    state_d = S_PUSH;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_PUSH: begin
                if (!fifo_full) begin
                    pend_d[idx_q] = 1'b0;
                    state_d       = S_SCAN;
                end
            end
            S_DONE: begin
                sweep_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointers and occupancy; a push never coincides with a full FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {err_q, idx_q, val_q};
        end
    end

endmodule

// File: tb/tb_freq_sweep_master.sv
// tb_freq_sweep_master
// Randomized bench: a behavioural frequency-counter slave answers the master's bus
// traffic, and a reference list of expected results (built from the sweep mask)
// is compared against everything the result FIFO delivers.
module tb_freq_sweep_master;

    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int ND   = 24;
    localparam int FD   = 4;
    localparam int TMO  = 64;
    localparam int IDXW = 5;
    localparam int EW   = 1 + IDXW + DW;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          sweep_start;
    logic [ND-1:0] sweep_mask;
    logic [DW-1:0] samples_cfg;
    logic          busy;
    logic          sweep_done;
    logic [AW-1:0] m_address;
    logic          m_read;
    logic [DW-1:0] m_readdata;
    logic          m_readdatavalid;
    logic          m_write;
    logic [DW-1:0] m_writedata;
    logic          irq;
    logic          res_valid;
    logic          res_ready;
    logic [EW-1:0] res_data;
    logic [CW-1:0] res_count;

    freq_sweep_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NDESIGNS(ND), .FIFO_DEPTH(FD), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .sweep_start(sweep_start), .sweep_mask(sweep_mask),
        .samples_cfg(samples_cfg), .busy(busy), .sweep_done(sweep_done),
        .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .m_write(m_write), .m_writedata(m_writedata),
        .irq(irq), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_count(res_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Counter slave configuration per design
    logic [DW-1:0] vals    [ND];
    int            delays  [ND];
    bit            noIrq   [ND];

    // Reference expectations
    logic [EW-1:0] expQ [$];
    int            selQ [$];
    logic [DW-1:0] expSamples;
    int            doneCount = 0;
    int            busCount  = 0;
    int            wrPhase   = 0;
    bit            randReady = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural frequency counter: irq some cycles after START, cleared when the result is read.
    int            curSel;
    bit            armed;
    int            cnt;
    int            rdPend;
    always @(posedge clk) begin
        if (rst) begin
            irq             <= 1'b0;
            m_readdatavalid <= 1'b0;
            m_readdata      <= '0;
            armed           <= 1'b0;
            cnt             <= 0;
            rdPend          <= 0;
            curSel          <= 0;
        end else begin
            m_readdatavalid <= 1'b0;
            if (m_write && m_address == 8'd1) begin
                curSel <= int'(m_writedata) % ND;
            end
            if (m_write && m_address == 8'd2 && m_writedata == 16'd1) begin
                armed <= 1'b1;
                cnt   <= delays[curSel];
            end else if (armed) begin
                if (cnt == 0) begin
                    armed <= 1'b0;
                    if (!noIrq[curSel]) irq <= 1'b1;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (m_read && m_address == 8'd3) begin
                rdPend <= int'($urandom_range(1, 3));
            end else if (rdPend > 0) begin
                if (rdPend == 1) begin
                    m_readdatavalid <= 1'b1;
                    m_readdata      <= vals[curSel];
                    irq             <= 1'b0;
                end
                rdPend <= rdPend - 1;
            end
        end
    end

    // Bus protocol, write sequence and result stream checks.
    always @(negedge clk) begin
        if (rst) begin
            wrPhase = 0;
        end else begin
            if (sweep_done) doneCount++;
            if (m_read || m_write) begin
                busCount++;
                checkOutput("oneStrobe", 64'(m_read && m_write), 0);
            end else begin
                checkOutput("idleBus", {m_address, m_writedata}, 0);
            end
            if (m_write) begin
                checkOutput("wrAddr", m_address, wrPhase);
                case (wrPhase)
                    0: checkOutput("wrSamples", m_writedata, expSamples);
                    1: begin
                        if (selQ.size() == 0) checkOutput("selUnexpected", 1, 0);
                        else checkOutput("wrSelect", m_writedata, selQ.pop_front());
                    end
                    default: checkOutput("wrStart", m_writedata, 1);
                endcase
                wrPhase = (wrPhase + 1) % 3;
            end
            if (m_read) checkOutput("rdAddr", m_address, 3);
            if (res_valid && res_ready) begin
                if (expQ.size() == 0) checkOutput("popUnexpected", res_data, 0);
                else checkOutput("resEntry", res_data, expQ.pop_front());
            end
        end
    end

    task automatic randomizeDesigns(input int errOneIn);
        for (int i = 0; i < ND; i++) begin
            vals[i]   = DW'($urandom);
            delays[i] = int'($urandom_range(0, 40));
            noIrq[i]  = (errOneIn > 0) && ($urandom_range(1, errOneIn) == 1);
        end
    endtask

    task automatic pulseStart(input logic [ND-1:0] mask, input logic [DW-1:0] samples);
        @(posedge clk); #1;
        sweep_mask  = mask;
        samples_cfg = samples;
        sweep_start = 1'b1;
        @(posedge clk); #1;
        sweep_start = 1'b0;
        sweep_mask  = ND'($urandom);
        samples_cfg = DW'($urandom);
    endtask

    // Builds the expected result list straight from the mask, then launches the sweep.
    task automatic applyStimulus(input logic [ND-1:0] mask, input logic [DW-1:0] samples);
        expSamples = samples;
        for (int i = 0; i < ND; i++) begin
            if (mask[i]) begin
                selQ.push_back(i);
                expQ.push_back({noIrq[i], IDXW'(i), noIrq[i] ? 16'hFFFF : vals[i]});
            end
        end
        pulseStart(mask, samples);
    endtask

    task automatic waitDone(input int budget);
        int n  = 0;
        int d0 = doneCount;
        while (doneCount == d0 && n < budget) begin
            @(posedge clk); #1;
            if (randReady) res_ready = 1'($urandom_range(0, 1));
            n++;
        end
        checkOutput("sweepDone", 64'(doneCount != d0), 1);
        checkOutput("busyAfterDone", busy, 0);
        randReady = 1'b0;
        res_ready = 1'b1;
        n = 0;
        while (res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resultsDelivered", expQ.size(), 0);
        checkOutput("selectsSeen", selQ.size(), 0);
        checkOutput("donePulses", doneCount - d0, 1);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0;
        int n;
        bit found;
        logic [ND-1:0] m;

        rst         = 1'b1;
        sweep_start = 1'b0;
        sweep_mask  = '0;
        samples_cfg = '0;
        res_ready   = 1'b1;
        expSamples  = '0;
        randomizeDesigns(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", sweep_done, 0);
        checkOutput("rstValid", res_valid, 0);
        checkOutput("rstCount", res_count, 0);
        checkOutput("rstStrobes", {m_read, m_write}, 0);

        $display("[TB] directed sweep, mask 0x000005");
        vals[0] = 16'h1234; vals[2] = 16'h0ABC;
        delays[0] = 50; delays[2] = 50;
        applyStimulus(24'h000005, 16'd100);
        waitDone(1000);

        $display("[TB] empty mask");
        b0 = busCount;
        pulseStart('0, 16'd7);
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (sweep_done) found = 1'b1;
        end
        checkOutput("mask0Done", found, 1);
        checkOutput("mask0Bus", busCount - b0, 0);
        checkOutput("mask0Fifo", res_count, 0);

        $display("[TB] irq timeout on design 1");
        randomizeDesigns(0);
        noIrq[1] = 1'b1;
        applyStimulus(24'h000007, 16'd55);
        waitDone(1000);

        $display("[TB] FIFO backpressure stall");
        randomizeDesigns(0);
        m = '0;
        while ($countones(m) < 6) m[$urandom_range(0, ND - 1)] = 1'b1;
        res_ready = 1'b0;
        applyStimulus(m, 16'd300);
        n = 0;
        while (res_count != 3'd4 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("stallFill", res_count, 4);
        repeat (150) @(posedge clk);
        #1 b0 = busCount;
        repeat (50) @(posedge clk);
        #1;
        checkOutput("stallCount", res_count, 4);
        checkOutput("stallBusy", busy, 1);
        checkOutput("stallNoBus", busCount - b0, 0);
        res_ready = 1'b1;
        waitDone(2000);

        $display("[TB] reset during measurement");
        randomizeDesigns(0);
        delays[0] = 40;
        b0 = busCount;
        applyStimulus(24'h000003, 16'd9);
        n = 0;
        while (busCount - b0 < 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortValid", res_valid, 0);
        checkOutput("abortStrobes", {m_read, m_write}, 0);
        checkOutput("abortDone", sweep_done, 0);
        expQ.delete();
        selQ.delete();
        applyStimulus(24'h000003, 16'd10);
        waitDone(1000);

        $display("[TB] restart ignored while busy");
        randomizeDesigns(0);
        applyStimulus(24'h0000C0, 16'd77);
        repeat (20) @(posedge clk);
        pulseStart(24'h000001, 16'd999);
        waitDone(1000);

        for (int r = 0; r < 3; r++) begin
            $display("[TB] random sweep %0d", r);
            randomizeDesigns(8);
            randReady = 1'b1;
            applyStimulus(ND'($urandom & $urandom), DW'($urandom));
            waitDone(4000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
